// File: rtl/pc_unit_if.sv
// Control/ALU strobes into the PC stage and the PC-side state back out to the datapath muxes.
interface pc_unit_if #(parameter int WIDTH = 16);
   logic             ctl_PCWrite;
   logic             ctl_PCSrc;
   logic             ctl_branch;
   logic [1:0]       ctl_branchType;
   logic             ctl_IRWrite;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_neg;
   logic             alu_ovf;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] old_pc;
   logic [WIDTH-1:0] target_q;
   logic             branch_taken;
   logic             misalign_err;
   logic [15:0]      retired_cnt;
   logic [15:0]      taken_cnt;

   modport master (
      output ctl_PCWrite, ctl_PCSrc, ctl_branch, ctl_branchType, ctl_IRWrite,
             alu_result, alu_zero, alu_neg, alu_ovf,
      input  pc, old_pc, target_q, branch_taken, misalign_err, retired_cnt, taken_cnt
   );

   modport slave (
      input  ctl_PCWrite, ctl_PCSrc, ctl_branch, ctl_branchType, ctl_IRWrite,
             alu_result, alu_zero, alu_neg, alu_ovf,
      output pc, old_pc, target_q, branch_taken, misalign_err, retired_cnt, taken_cnt
   );
endinterface

// File: rtl/pc_unit.sv
// PC stage: owns PC, fetched-instruction PC and branch target; resolves conditional branches.
// Define PC_TRACE_EN to build the saturating fetch/taken-branch trace counters.
module pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          WIDTH    = 16
) (
   input  logic       CLK,
   input  logic       Reset,
   pc_unit_if.slave   bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] old_pc_q;
   logic [WIDTH-1:0] target_q;
   logic             taken_q;
   logic             misalign_q;
   logic             cond;
   logic             pc_we;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      cond = 1'b0;
      unique case (bus.ctl_branchType)
         2'b00: cond = bus.alu_zero;
         2'b01: cond = !bus.alu_zero;
         2'b10: cond = bus.alu_neg ^ bus.alu_ovf;
         2'b11: cond = !(bus.alu_neg ^ bus.alu_ovf);
         default: cond = 1'b0;
      endcase
   end

   assign pc_we = bus.ctl_PCWrite & (!bus.ctl_branch | cond);
   assign nxt   = bus.ctl_PCSrc ? target_q : bus.alu_result;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pc_q       <= WIDTH'(RESET_PC);
         old_pc_q   <= '0;
         target_q   <= '0;
         taken_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         // old_pc samples the pre-update pc even when pc is written this same edge
         if (bus.ctl_IRWrite)
            old_pc_q <= pc_q;
         if (bus.ctl_branch && !bus.ctl_PCWrite)
            target_q <= bus.alu_result;
         if (pc_we) begin
            pc_q <= {nxt[WIDTH-1:1], 1'b0};
            if (nxt[0])
               misalign_q <= 1'b1;
         end
         taken_q <= pc_we & bus.ctl_branch;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.old_pc       = old_pc_q;
   assign bus.target_q     = target_q;
   assign bus.branch_taken = taken_q;
   assign bus.misalign_err = misalign_q;

`ifdef PC_TRACE_EN
   logic [15:0] retired_q;
   logic [15:0] taken_cnt_q;

   // taken_cnt steps on the same edge that raises branch_taken, so both appear together
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         retired_q   <= '0;
         taken_cnt_q <= '0;
      end else begin
         if (bus.ctl_IRWrite && retired_q != 16'hFFFF)
            retired_q <= retired_q + 16'd1;
         if (pc_we && bus.ctl_branch && taken_cnt_q != 16'hFFFF)
            taken_cnt_q <= taken_cnt_q + 16'd1;
      end
   end

   assign bus.retired_cnt = retired_q;
   assign bus.taken_cnt   = taken_cnt_q;
`else
   assign bus.retired_cnt = 16'h0000;
   assign bus.taken_cnt   = 16'h0000;
`endif

endmodule
